new_usb_frametimer: RTL and testbench
=====================================

// Module: new_usb_frametimer
// PURPOSE
// - Full-speed USB frame timer for the OHCI-style host controller: counts bit times per frame,
//   keeps the frame number and emits start-of-frame (SOF).
// - Upstream of new_usb_nonperiodiccounter: sof_o restarts its control/bulk ratio window, and
//   periodic_o / budget flags gate when nonperiodic EDs may be served.
// PARAMETERS
// - FiWidth     14  width of FrameInterval / FrameRemaining (bit times)
// - FsmpsWidth  15  width of FSLargestDataPacket (bits)
// - LstWidth    12  width of LSThreshold (bit times)
// - FnWidth     16  frame number width
// PORTS
// - soc_clk_i     in   1           system clock
// - soc_rst_ni    in   1           reset, synchronous active-low
// - bit_tick_i    in   1           one-cycle strobe per full-speed bit time (12 MHz)
// - run_i         in   1           controller Operational; low freezes the timer
// - fi_i          in   FiWidth     FrameInterval; default programming 11999
// - fit_i         in   1           FrameIntervalToggle written by software
// - fsmps_i       in   FsmpsWidth  FSLargestDataPacket
// - ps_i          in   FiWidth     PeriodicStart
// - lst_i         in   LstWidth    LSThreshold
// - fr_o          out  FiWidth     FrameRemaining
// - frt_o         out  1           FrameRemainingToggle
// - fn_o          out  FnWidth     FrameNumber
// - sof_o         out  1           one-cycle SOF pulse
// - periodic_o    out  1           periodic window active (fr_o <= ps_i)
// - fs_ok_o       out  1           full-speed transaction fits (fr_o >= fsmps_i)
// - ls_ok_o       out  1           low-speed transaction fits (fr_o > lst_i)
// - fno_o         out  1           one-cycle FrameNumberOverflow pulse
// BEHAVIOUR
// - Reset: fr_o=0, frt_o=0, fn_o=0, fi_q=0, sof_o=0, fno_o=0.
//   Combinational flags follow the regs: periodic_o=1 (0<=ps), fs_ok_o=(fsmps_i==0), ls_ok_o=0.
// - All state is registered. Outputs are combinational only from regs and ps_i/fsmps_i/lst_i.
// - Idle (run_i=0): fr_o is forced to 0 each cycle. fn_o, frt_o and fi_q hold.
//   sof_o and fno_o stay 0.
// - Count (run_i=1, bit_tick_i=1, fr_o!=0): fr_o <= fr_o-1.
// - Boundary (run_i=1, bit_tick_i=1, fr_o==0) updates, all in the same cycle:
//   - fi_q <= fi_i
//   - fr_o <= fi_i
//   - frt_o <= fit_i
//   - fn_o <= fn_o+1 (mod 2^FnWidth)
//   - sof_o=1 for exactly that one cycle
//   - Frame length is therefore fi_q+1 bit times.
// - The first boundary after run_i rises happens on the first bit_tick_i, since fr_o is 0.
//   That boundary produces SOF immediately.
// - fi_i and fit_i are sampled only at a boundary. Mid-frame writes take effect next frame.
// - No bit_tick_i: no state change.
// - run_i falling in the same cycle as a boundary tick: run_i wins. fr_o=0, no SOF, fn_o unchanged.
// - fi_i=0: every tick is a boundary, one SOF per bit_tick_i. This is legal; no lockup.
// - ps_i > fi_q: periodic_o is high for the whole frame.
// - Budget compares are unsigned:
//   - fs_ok_o compares fr_o zero-extended to FsmpsWidth against fsmps_i.
//   - ls_ok_o compares fr_o against lst_i zero-extended to FiWidth.
// - Synchronous reset asserted mid-frame returns all state to reset values on the next edge.
//   It overrides all other inputs.
// CONFIGURATION
// - NEW_USB_FRAMETIMER_FNO_EN
//   - Defined: fno_o pulses for one cycle at a boundary where fn_o bit FnWidth-1 toggles
//     (0x7FFF->0x8000 and 0xFFFF->0x0000), coincident with sof_o.
//   - Undefined: fno_o is tied to 0, no extra logic.
// TESTING
// - Reset, run_i=1, fi_i=11999, tick every 4 clk
//   -> first tick: sof_o, fr_o=11999, fn_o=1.
//   -> next SOF exactly 12000 ticks later, fn_o=2.
// - Write fi_i=11998 with fit_i=1 mid-frame
//   -> current frame stays 12000 ticks.
//   -> at boundary frt_o=1, fr_o=11998, next frame is 11999 ticks.
// - ps_i=10800, fsmps_i=0x2778, lst_i=0x628
//   -> periodic_o rises when fr_o reaches 10800 and falls at SOF.
//   -> fs_ok_o falls below fr_o=10104; ls_ok_o falls at fr_o=1576.
// - run_i dropped on the cycle of a boundary tick
//   -> no sof_o, fr_o=0, fn_o held.
//   -> on re-run, SOF arrives on the first tick.
// - Preload fn_o to 0x7FFF and 0xFFFF via frames with fi_i=0
//   -> with NEW_USB_FRAMETIMER_FNO_EN: fno_o pulses at 0x8000 and 0x0000.
//   -> without the macro: fno_o stays 0.
// - Assert soc_rst_ni low mid-frame
//   -> next edge: fr_o=0, fn_o=0, frt_o=0, sof_o=0. Counting resumes cleanly after release.

Source files
------------

// File: rtl/new_usb_frametimer.sv
// Full-speed USB frame timer: bit-time down-counter, frame number and SOF generation.
// Optional macro NEW_USB_FRAMETIMER_FNO_EN enables the FrameNumberOverflow pulse on fno_o.
module new_usb_frametimer #(
    parameter int FiWidth    = 14,
    parameter int FsmpsWidth = 15,
    parameter int LstWidth   = 12,
    parameter int FnWidth    = 16
) (
    input  logic                  soc_clk_i,
    input  logic                  soc_rst_ni,
    input  logic                  bit_tick_i,
    input  logic                  run_i,
    input  logic [FiWidth-1:0]    fi_i,
    input  logic                  fit_i,
    input  logic [FsmpsWidth-1:0] fsmps_i,
    input  logic [FiWidth-1:0]    ps_i,
    input  logic [LstWidth-1:0]   lst_i,
    output logic [FiWidth-1:0]    fr_o,
    output logic                  frt_o,
    output logic [FnWidth-1:0]    fn_o,
    output logic                  sof_o,
    output logic                  periodic_o,
    output logic                  fs_ok_o,
    output logic                  ls_ok_o,
    output logic                  fno_o
);

    logic [FiWidth-1:0] fr_q, fr_d;
    logic               frt_q, frt_d;
    logic [FnWidth-1:0] fn_q, fn_d;
    logic               sof_q, sof_d;

    // The reload value lands directly in fr_q, so the frame lasts fi_i+1 ticks.
    always_comb begin
        fr_d  = fr_q;
        frt_d = frt_q;
        fn_d  = fn_q;
        sof_d = 1'b0;
        if (!run_i) begin
            fr_d = '0;
        end else if (bit_tick_i) begin
            if (fr_q == '0) begin
                fr_d  = fi_i;
                frt_d = fit_i;
                fn_d  = fn_q + FnWidth'(1);
                sof_d = 1'b1;
            end else begin
                fr_d = fr_q - FiWidth'(1);
            end
        end
    end

    always_ff @(posedge soc_clk_i) begin
        if (!soc_rst_ni) begin
            fr_q  <= '0;
            frt_q <= 1'b0;
            fn_q  <= '0;
            sof_q <= 1'b0;
        end else begin
            fr_q  <= fr_d;
            frt_q <= frt_d;
            fn_q  <= fn_d;
            sof_q <= sof_d;
        end
    end

`ifdef NEW_USB_FRAMETIMER_FNO_EN
    logic fno_q;

    always_ff @(posedge soc_clk_i) begin
        if (!soc_rst_ni) begin
            fno_q <= 1'b0;
        end else begin
            fno_q <= sof_d && (fn_d[FnWidth-1] != fn_q[FnWidth-1]);
        end
    end

    assign fno_o = fno_q;
`else
    assign fno_o = 1'b0;
`endif

    assign fr_o       = fr_q;
    assign frt_o      = frt_q;
    assign fn_o       = fn_q;
    assign sof_o      = sof_q;
    assign periodic_o = (fr_q <= ps_i);
    assign fs_ok_o    = (FsmpsWidth'(fr_q) >= fsmps_i);
    assign ls_ok_o    = (fr_q > FiWidth'(lst_i));

endmodule

// File: tb/tb_new_usb_frametimer.sv
// Directed-vector bench for new_usb_frametimer; honours NEW_USB_FRAMETIMER_FNO_EN when defined.
module tb_new_usb_frametimer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_tick_i;
    logic        run_i;
    logic [13:0] fi_i;
    logic        fit_i;
    logic [14:0] fsmps_i;
    logic [13:0] ps_i;
    logic [11:0] lst_i;
    logic [13:0] fr_o;
    logic        frt_o;
    logic [15:0] fn_o;
    logic        sof_o;
    logic        periodic_o;
    logic        fs_ok_o;
    logic        ls_ok_o;
    logic        fno_o;

    int vectors     = 0;
    int miscompares = 0;
    int gap         = 3;
    int sof_seen;
    int fno_seen;

`ifdef NEW_USB_FRAMETIMER_FNO_EN
    localparam logic EXP_FNO = 1'b1;
`else
    localparam logic EXP_FNO = 1'b0;
`endif

    always #5 clk = ~clk;

    new_usb_frametimer dut (
        .soc_clk_i  (clk),
        .soc_rst_ni (rst_n),
        .bit_tick_i (bit_tick_i),
        .run_i      (run_i),
        .fi_i       (fi_i),
        .fit_i      (fit_i),
        .fsmps_i    (fsmps_i),
        .ps_i       (ps_i),
        .lst_i      (lst_i),
        .fr_o       (fr_o),
        .frt_o      (frt_o),
        .fn_o       (fn_o),
        .sof_o      (sof_o),
        .periodic_o (periodic_o),
        .fs_ok_o    (fs_ok_o),
        .ls_ok_o    (ls_ok_o),
        .fno_o      (fno_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Strobe one bit time after gap idle cycles; returns on the negedge after the tick edge.
    task automatic tick();
        repeat (gap) @(negedge clk);
        bit_tick_i = 1'b1;
        @(negedge clk);
        bit_tick_i = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        run_i      = 1'b0;
        bit_tick_i = 1'b0;
        fi_i       = 14'd11999;
        fit_i      = 1'b0;
        fsmps_i    = 15'h2778;
        ps_i       = 14'd10800;
        lst_i      = 12'h628;
        repeat (2) @(negedge clk);

        chk("rst_fr",       32'(fr_o), 32'd0);
        chk("rst_frt",      32'(frt_o), 32'd0);
        chk("rst_fn",       32'(fn_o), 32'd0);
        chk("rst_sof",      32'(sof_o), 32'd0);
        chk("rst_fno",      32'(fno_o), 32'd0);
        chk("rst_periodic", 32'(periodic_o), 32'd1);
        chk("rst_fs_ok",    32'(fs_ok_o), 32'd0);
        chk("rst_ls_ok",    32'(ls_ok_o), 32'd0);
        fsmps_i = 15'd0;
        #1;
        chk("rst_fs_ok_zero", 32'(fs_ok_o), 32'd1);
        fsmps_i = 15'h2778;

        rst_n = 1'b1;
        run_i = 1'b1;
        @(negedge clk);
        chk("run_no_tick_fr", 32'(fr_o), 32'd0);
        chk("run_no_tick_sof", 32'(sof_o), 32'd0);

        // First tick after run: immediate boundary.
        tick();
        chk("sof1_sof", 32'(sof_o), 32'd1);
        chk("sof1_fr",  32'(fr_o), 32'd11999);
        chk("sof1_fn",  32'(fn_o), 32'd1);
        chk("sof1_frt", 32'(frt_o), 32'd0);
        chk("sof1_periodic", 32'(periodic_o), 32'd0);
        chk("sof1_fs_ok", 32'(fs_ok_o), 32'd1);
        chk("sof1_ls_ok", 32'(ls_ok_o), 32'd1);
        @(negedge clk);
        chk("sof1_pulse_width", 32'(sof_o), 32'd0);

        gap      = 0;
        sof_seen = 0;
        for (int i = 1; i <= 11999; i++) begin
            tick();
            sof_seen += int'(sof_o);
            if (i == 6000) begin
                fi_i  = 14'd11998;
                fit_i = 1'b1;
            end
            case (11999 - i)
                10801: chk("periodic_above_ps", 32'(periodic_o), 32'd0);
                10800: chk("periodic_at_ps",    32'(periodic_o), 32'd1);
                10104: chk("fs_ok_at_fsmps",    32'(fs_ok_o), 32'd1);
                10103: chk("fs_ok_below_fsmps", 32'(fs_ok_o), 32'd0);
                1577:  chk("ls_ok_above_lst",   32'(ls_ok_o), 32'd1);
                1576:  chk("ls_ok_at_lst",      32'(ls_ok_o), 32'd0);
                5997:  chk("midframe_fi_ignored", 32'(fr_o), 32'd5997);
                default: ;
            endcase
        end
        chk("frame1_no_early_sof", 32'(sof_seen), 32'd0);
        chk("frame1_end_fr", 32'(fr_o), 32'd0);
        chk("frame1_end_fn", 32'(fn_o), 32'd1);
        chk("frame1_end_periodic", 32'(periodic_o), 32'd1);

        tick();
        chk("sof2_sof", 32'(sof_o), 32'd1);
        chk("sof2_fr",  32'(fr_o), 32'd11998);
        chk("sof2_frt", 32'(frt_o), 32'd1);
        chk("sof2_fn",  32'(fn_o), 32'd2);
        chk("sof2_periodic", 32'(periodic_o), 32'd0);

        // Idle forces fr to 0 and holds the rest.
        fi_i  = 14'd2;
        fit_i = 1'b0;
        run_i = 1'b0;
        @(negedge clk);
        chk("idle_fr",  32'(fr_o), 32'd0);
        chk("idle_fn",  32'(fn_o), 32'd2);
        chk("idle_frt", 32'(frt_o), 32'd1);
        chk("idle_sof", 32'(sof_o), 32'd0);
        run_i = 1'b1;
        gap   = 3;
        tick();
        chk("rerun_sof", 32'(sof_o), 32'd1);
        chk("rerun_fn",  32'(fn_o), 32'd3);
        chk("rerun_fr",  32'(fr_o), 32'd2);
        chk("rerun_frt", 32'(frt_o), 32'd0);
        chk("ps_gt_fi_periodic", 32'(periodic_o), 32'd1);
        tick();
        tick();
        chk("short_frame_end_fr", 32'(fr_o), 32'd0);
        chk("short_frame_end_sof", 32'(sof_o), 32'd0);

        // Run drops on the boundary tick: run wins.
        @(negedge clk);
        bit_tick_i = 1'b1;
        run_i      = 1'b0;
        @(negedge clk);
        bit_tick_i = 1'b0;
        chk("drop_sof", 32'(sof_o), 32'd0);
        chk("drop_fr",  32'(fr_o), 32'd0);
        chk("drop_fn",  32'(fn_o), 32'd3);
        run_i = 1'b1;
        fit_i = 1'b1;
        tick();
        chk("rerun2_sof", 32'(sof_o), 32'd1);
        chk("rerun2_fn",  32'(fn_o), 32'd4);
        chk("rerun2_frt", 32'(frt_o), 32'd1);
        tick();
        chk("pre_rst_fr", 32'(fr_o), 32'd1);

        // Reset mid-frame overrides a simultaneous tick.
        @(negedge clk);
        rst_n      = 1'b0;
        bit_tick_i = 1'b1;
        @(negedge clk);
        chk("midrst_fr",  32'(fr_o), 32'd0);
        chk("midrst_fn",  32'(fn_o), 32'd0);
        chk("midrst_frt", 32'(frt_o), 32'd0);
        chk("midrst_sof", 32'(sof_o), 32'd0);
        rst_n      = 1'b1;
        bit_tick_i = 1'b0;
        tick();
        chk("postrst_sof", 32'(sof_o), 32'd1);
        chk("postrst_fr",  32'(fr_o), 32'd2);
        chk("postrst_fn",  32'(fn_o), 32'd1);

        // fi_i=0: every tick is a boundary; walk fn up to both MSB toggles.
        fi_i  = 14'd0;
        run_i = 1'b0;
        @(negedge clk);
        run_i    = 1'b1;
        gap      = 0;
        fno_seen = 0;
        sof_seen = 0;
        for (int i = 0; i < 32766; i++) begin
            tick();
            fno_seen += int'(fno_o);
            sof_seen += int'(sof_o);
        end
        chk("fi0_fn_7fff", 32'(fn_o), 32'h7FFF);
        chk("fi0_every_tick_sof", 32'(sof_seen), 32'd32766);
        chk("fi0_fr", 32'(fr_o), 32'd0);
        chk("fno_quiet_low", 32'(fno_seen), 32'd0);
        tick();
        chk("fn_8000", 32'(fn_o), 32'h8000);
        chk("fno_8000", 32'(fno_o), 32'(EXP_FNO));
        chk("sof_8000", 32'(sof_o), 32'd1);
        fno_seen = 0;
        for (int i = 0; i < 32767; i++) begin
            tick();
            fno_seen += int'(fno_o);
        end
        chk("fn_ffff", 32'(fn_o), 32'hFFFF);
        chk("fno_quiet_high", 32'(fno_seen), 32'd0);
        tick();
        chk("fn_wrap", 32'(fn_o), 32'h0000);
        chk("fno_wrap", 32'(fno_o), 32'(EXP_FNO));
        @(negedge clk);
        chk("fno_pulse_width", 32'(fno_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
